eth_header_builder: RTL
=======================

# eth_header_builder

Transmit-side counterpart of the Ethernet receive parser. It accepts one `eth_metadata_t` record per frame and serializes the corresponding L2 header as a byte stream. The header is destination MAC, source MAC, an optional 802.1Q tag, then ethertype. After the header it forwards the frame payload from an upstream byte stream until the last payload byte. It sits between the metadata/payload producers and the MAC transmit interface.

## Interface
- No parameters. All widths come from `eth_parser_pkg`.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `metadata` in `eth_metadata_t` — frame descriptor. Fields used: `dest_mac`, `src_mac`, `vlan_present`, `vlan_id`, `ethertype`, `l2_header_len`. The `is_*` flags are ignored.
- `metadata_valid` in 1 — descriptor valid.
- `metadata_ready` out 1 — block can accept a descriptor.
- `pl_data` in 8 — payload byte.
- `pl_valid` in 1 — payload byte valid.
- `pl_last` in 1 — final payload byte of the frame.
- `pl_ready` out 1 — payload byte consumed.
- `tx_data` out 8 — output byte.
- `tx_valid` out 1 — output byte valid.
- `tx_ready` in 1 — downstream accepts the byte.
- `tx_sof` out 1 — qualifies the first header byte.
- `tx_last` out 1 — qualifies the final payload byte.
- `hdr_len_err` out 1 — one-cycle pulse: `metadata.l2_header_len` disagrees with the computed header length.
- `frames_sent` out 16 — count of completed frames; wraps from 0xFFFF to 0.

## Operation
- FSM states: `IDLE`, `HDR`, `PAYLOAD`.
- **IDLE**
  - `metadata_ready`=1.
  - On `metadata_valid & metadata_ready`: capture the descriptor into registers, clear `byte_idx` (5-bit), go to `HDR`.
  - Computed header length: 18 if the VLAN tag is inserted, else 14.
- **HDR**
  - `tx_valid`=1.
  - `tx_data` is selected by `byte_idx` from the captured descriptor:
    - bytes 0–5: `dest_mac[47:0]`, MSB byte first
    - bytes 6–11: `src_mac`, MSB byte first
    - VLAN frames, bytes 12–15: 0x81, 0x00, {PCP=3'b0, DEI=0, `vlan_id[11:8]`}, `vlan_id[7:0]`
    - last two bytes: `ethertype[15:8]`, `ethertype[7:0]`
  - `byte_idx` increments on each `tx_valid & tx_ready` handshake.
  - The handshake on the final header byte moves the FSM to `PAYLOAD`.
  - `pl_ready`=0 throughout `HDR`.
- **PAYLOAD**
  - Pass-through: `tx_data`=`pl_data`, `tx_valid`=`pl_valid`, `pl_ready`=`tx_ready`, `tx_last`=`pl_last & pl_valid`.
  - On `pl_valid & tx_ready & pl_last`: increment `frames_sent`, go to `IDLE`.
- `tx_sof` = (state==`HDR`) & (`byte_idx`==0).
- `hdr_len_err` is registered from the capture cycle and asserts for exactly one cycle. The header is always built from the computed length, never from `l2_header_len`.
- While `tx_ready`=0, `tx_data`/`tx_valid` are held stable; the index does not advance.
- `metadata_valid` outside `IDLE` is ignored (not captured); the producer holds it until ready.
- A `pl_valid` beat in `IDLE`/`HDR` is not consumed.
- An ethertype of 0x0000 is emitted as-is; there is no substitution.

## Timing
- Reset values:
  - state=`IDLE`, `byte_idx`=0, captured descriptor=0, `frames_sent`=0, `hdr_len_err`=0.
  - `tx_valid`=`tx_sof`=`tx_last`=`pl_ready`=0, `tx_data`=0.
  - `metadata_ready`=0 while `rst`=1, and 1 from the first cycle after release.
- Descriptor accepted at edge N: `tx_sof`/byte 0 is valid in cycle N+1.
- Header throughput: 1 byte/cycle with `tx_ready`=1. With `tx_ready` constant, the first payload beat is presentable at N+15 (untagged) or N+19 (tagged).
- Final payload handshake at edge M: `metadata_ready`=1 in cycle M+1; the next frame's `tx_sof` comes at M+2 earliest. There is no overlap between frames.
- Payload path is combinational (zero added latency). Header path is registered state with combinational byte select.
- `rst` asserted mid-frame:
  - immediate return to `IDLE`; the partial frame is truncated without `tx_last`
  - `frames_sent` resets to 0
  - downstream handles the truncation.

## Configuration
- `ETH_TX_VLAN_EN` defined: a tag is inserted when `metadata.vlan_present`=1; computed length is 18.
- `ETH_TX_VLAN_EN` undefined:
  - `vlan_present`/`vlan_id` are ignored and every header is 14 bytes.
  - `hdr_len_err` still compares against 14, so a tagged descriptor with length 18 pulses the error.

## Structure
- Add to `eth_parser_pkg`:
  - `ETH_TPID_VLAN` = 16'h8100
  - `ETH_HDR_LEN` = 5'd14
  - `ETH_VLAN_HDR_LEN` = 5'd18
  - `eth_tx_state_t` enum {IDLE, HDR, PAYLOAD}
- Reuse the existing `mac_addr_t`, `ethertype_t`, `eth_metadata_t`.
- One sub-module: `eth_hdr_byte_sel`, a combinational map of (captured descriptor, `byte_idx`, vlan flag) to a header byte. The FSM, counters and handshakes stay in the top.

## Test plan
- **Untagged frame, `tx_ready`=1.** Stimulus: dest 00:11:22:33:44:55, src 66:77:88:99:AA:BB, ethertype 0x0800, len 14, 4 payload bytes DE AD BE EF. Expect: 18 bytes in 18 consecutive cycles, `tx_sof` on byte 0x00, `tx_last` on 0xEF, `frames_sent`=1.
- **Tagged frame (`ETH_TX_VLAN_EN` defined).** Stimulus: vlan_id 0x123, ethertype 0x86DD, len 18. Expect: bytes 12–15 = 81 00 01 23, then 86 DD. Build without the macro: 14-byte header and a `hdr_len_err` pulse.
- **Backpressure.** Stimulus: `tx_ready` toggles 1,0,0,1 during the header and payload. Expect: no byte dropped or repeated, `tx_data` stable while stalled, `pl_ready` low in `HDR`.
- **Back-to-back frames.** Stimulus: second descriptor held valid during the first frame's payload. Expect: captured only after `tx_last`, next `tx_sof` at M+2, `frames_sent`=2.
- **Length mismatch.** Stimulus: untagged descriptor with `l2_header_len`=18. Expect: one-cycle `hdr_len_err` pulse and a 14-byte header emitted.
- **Reset mid-frame.** Stimulus: `rst` asserted at header byte 7. Expect: `tx_valid`=0 immediately, `frames_sent`=0, `metadata_ready`=1 the first cycle after release, and the next frame correct.

Source files
------------

// File: rtl/eth_parser_pkg.sv
// Shared Ethernet L2 types for the receive parser and transmit header builder.
package eth_parser_pkg;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;

  typedef struct packed {
    mac_addr_t  dest_mac;
    mac_addr_t  src_mac;
    logic       vlan_present;
    logic [11:0] vlan_id;
    ethertype_t ethertype;
    logic [4:0] l2_header_len;
    logic       is_ipv4;
    logic       is_ipv6;
    logic       is_arp;
  } eth_metadata_t;

  localparam logic [15:0] ETH_TPID_VLAN    = 16'h8100;
  localparam logic [4:0]  ETH_HDR_LEN      = 5'd14;
  localparam logic [4:0]  ETH_VLAN_HDR_LEN = 5'd18;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} eth_tx_state_t;

  function automatic logic [4:0] eth_hdr_len(input logic vlan);
    return vlan ? ETH_VLAN_HDR_LEN : ETH_HDR_LEN;
  endfunction

endpackage

// File: rtl/eth_hdr_byte_sel.sv
// Combinational header byte select: maps the captured descriptor and byte index
// to the L2 header byte (dest MAC, src MAC, optional 802.1Q tag, ethertype).
module eth_hdr_byte_sel
  import eth_parser_pkg::*;
(
  input  mac_addr_t   dest_mac_i,
  input  mac_addr_t   src_mac_i,
  input  logic        vlan_i,
  input  logic [11:0] vlan_id_i,
  input  ethertype_t  ethertype_i,
  input  logic [4:0]  byte_idx_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = '0;
    case (byte_idx_i)
      5'd0:  byte_o = dest_mac_i[47:40];
      5'd1:  byte_o = dest_mac_i[39:32];
      5'd2:  byte_o = dest_mac_i[31:24];
      5'd3:  byte_o = dest_mac_i[23:16];
      5'd4:  byte_o = dest_mac_i[15:8];
      5'd5:  byte_o = dest_mac_i[7:0];
      5'd6:  byte_o = src_mac_i[47:40];
      5'd7:  byte_o = src_mac_i[39:32];
      5'd8:  byte_o = src_mac_i[31:24];
      5'd9:  byte_o = src_mac_i[23:16];
      5'd10: byte_o = src_mac_i[15:8];
      5'd11: byte_o = src_mac_i[7:0];
      // Untagged frames put the ethertype at 12/13; tagged frames shift it to 16/17.
      5'd12: byte_o = vlan_i ? ETH_TPID_VLAN[15:8] : ethertype_i[15:8];
      5'd13: byte_o = vlan_i ? ETH_TPID_VLAN[7:0]  : ethertype_i[7:0];
      5'd14: byte_o = vlan_i ? {4'b0000, vlan_id_i[11:8]} : '0;
      5'd15: byte_o = vlan_i ? vlan_id_i[7:0] : '0;
      5'd16: byte_o = vlan_i ? ethertype_i[15:8] : '0;
      5'd17: byte_o = vlan_i ? ethertype_i[7:0]  : '0;
      default: byte_o = '0;
    endcase
  end

endmodule

// File: rtl/eth_header_builder.sv
// Ethernet transmit header builder: serializes the L2 header from a descriptor,
// then passes payload through. Define ETH_TX_VLAN_EN to enable 802.1Q tag insertion.
module eth_header_builder
  import eth_parser_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  eth_metadata_t metadata,
  input  logic          metadata_valid,
  output logic          metadata_ready,
  input  logic [7:0]    pl_data,
  input  logic          pl_valid,
  input  logic          pl_last,
  output logic          pl_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          tx_sof,
  output logic          tx_last,
  output logic          hdr_len_err,
  output logic [15:0]   frames_sent
);

  eth_tx_state_t state_q, state_d;
  logic [4:0]    byte_idx_q, byte_idx_d;
  logic [15:0]   frames_q, frames_d;
  mac_addr_t     dest_q, src_q;
  ethertype_t    ethertype_q;
  logic          vlan_q;
  logic [11:0]   vlan_id_q;
  logic          hdr_len_err_q;
  logic          vlan_in, capture, unused_meta;
  logic [4:0]    last_idx;
  logic [7:0]    hdr_byte;

`ifdef ETH_TX_VLAN_EN
  assign vlan_in     = metadata.vlan_present;
  assign unused_meta = ^{metadata.is_ipv4, metadata.is_ipv6, metadata.is_arp};
`else
  assign vlan_in     = 1'b0;
  assign unused_meta = ^{metadata.vlan_present, metadata.is_ipv4, metadata.is_ipv6, metadata.is_arp};
`endif

  assign metadata_ready = (state_q == IDLE) & ~rst;
  assign capture        = metadata_ready & metadata_valid;
  assign last_idx       = eth_hdr_len(vlan_q) - 5'd1;
  assign tx_sof         = (state_q == HDR) & (byte_idx_q == 5'd0);
  assign hdr_len_err    = hdr_len_err_q;
  assign frames_sent    = frames_q;

  eth_hdr_byte_sel u_byte_sel (
    .dest_mac_i  (dest_q),
    .src_mac_i   (src_q),
    .vlan_i      (vlan_q),
    .vlan_id_i   (vlan_id_q),
    .ethertype_i (ethertype_q),
    .byte_idx_i  (byte_idx_q),
    .byte_o      (hdr_byte)
  );

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    frames_d   = frames_q;
    tx_valid   = 1'b0;
    tx_data    = '0;
    tx_last    = 1'b0;
    pl_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d    = HDR;
          byte_idx_d = '0;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
        if (tx_ready) begin
          byte_idx_d = byte_idx_q + 5'd1;
          if (byte_idx_q == last_idx) state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        tx_valid = pl_valid;
        tx_data  = pl_data;
        tx_last  = pl_last & pl_valid;
        pl_ready = tx_ready;
        if (pl_valid & tx_ready & pl_last) begin
          frames_d = frames_q + 16'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      byte_idx_q    <= '0;
      frames_q      <= '0;
      dest_q        <= '0;
      src_q         <= '0;
      ethertype_q   <= '0;
      vlan_q        <= 1'b0;
      vlan_id_q     <= '0;
      hdr_len_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      frames_q      <= frames_d;
      // The check uses the computed length; the header itself never follows l2_header_len.
      hdr_len_err_q <= capture & (metadata.l2_header_len != eth_hdr_len(vlan_in));
      if (capture) begin
        dest_q      <= metadata.dest_mac;
        src_q       <= metadata.src_mac;
        ethertype_q <= metadata.ethertype;
        vlan_q      <= vlan_in;
        vlan_id_q   <= metadata.vlan_id;
      end
    end
  end

endmodule
